rst_seq_ctrl: RTL and testbench

//   Staged reset sequencer downstream of the async-assert/sync-release reset synchronizer.

---
 rtl/rst_pkg.sv | 17 +
 rtl/rst_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rst_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package rst_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        DONE      = 2'd2,
        HOLD      = 2'd3
    } rst_seq_state_e;

    // Counter width for a terminal count of val-1; never narrower than one bit.
    function automatic int cnt_w(input int val);
        return $clog2((val < 2) ? 2 : val);
    endfunction

endpackage

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: filters PLL lock, then releases NUM_STAGES
// active-low reset domains one by one, STAGE_DLY cycles apart. Lock loss
// or a software request pulls every domain back into reset.
module rst_seq_ctrl
    import rst_pkg::*;
#(
    parameter int NUM_STAGES   = 4,
    parameter int STAGE_DLY    = 16,
    parameter int LOCK_FILT    = 8,
    parameter int SOFT_RST_CYC = 32
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  pll_lock_i,
    input  logic                  soft_rst_req_i,
    output logic [NUM_STAGES-1:0] rst_n_o,
    output logic                  seq_done_o,
    output logic                  busy_o
);

    if (NUM_STAGES < 1 || STAGE_DLY < 1 || LOCK_FILT < 1 || SOFT_RST_CYC < 1) begin : g_bad_param
        $error("rst_seq_ctrl: parameter below its minimum");
    end

    localparam int LOCK_W = cnt_w(LOCK_FILT);
    localparam int DLY_W  = cnt_w(STAGE_DLY);
    localparam int HOLD_W = cnt_w(SOFT_RST_CYC);
    localparam int IDX_W  = cnt_w(NUM_STAGES);

    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILT - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DLY - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SOFT_RST_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    rst_seq_state_e          state_q,     state_d;
    logic [LOCK_W-1:0]       lock_cnt_q,  lock_cnt_d;
    logic [DLY_W-1:0]        dly_cnt_q,   dly_cnt_d;
    logic [HOLD_W-1:0]       hold_cnt_q,  hold_cnt_d;
    logic [IDX_W-1:0]        stage_idx_q, stage_idx_d;
    logic [NUM_STAGES-1:0]   rst_n_q,     rst_n_d;
    logic                    done_q,      done_d;
    logic                    busy_q,      busy_d;

    // Next-state, counter and output-register logic
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        dly_cnt_d   = dly_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        stage_idx_d = stage_idx_q;
        rst_n_d     = rst_n_q;
        done_d      = done_q;
        busy_d      = busy_q;

        if (soft_rst_req_i) begin
            // Software request wins over everything, including lock loss.
            state_d    = HOLD;
            hold_cnt_d = '0;
            rst_n_d    = '0;
            done_d     = 1'b0;
            busy_d     = 1'b1;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (!pll_lock_i) begin
                        lock_cnt_d = '0;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        state_d     = RELEASE;
                        lock_cnt_d  = '0;
                        dly_cnt_d   = '0;
                        stage_idx_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!pll_lock_i) begin
                        state_d    = WAIT_LOCK;
                        lock_cnt_d = '0;
                        rst_n_d    = '0;
                        done_d     = 1'b0;
                        busy_d     = 1'b1;
                    end else if (dly_cnt_q == DLY_LAST) begin
                        rst_n_d[stage_idx_q] = 1'b1;
                        dly_cnt_d            = '0;
                        if (stage_idx_q == IDX_LAST) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            stage_idx_d = stage_idx_q + 1'b1;
                        end
                    end else begin
                        dly_cnt_d = dly_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!pll_lock_i) begin
                        state_d    = WAIT_LOCK;
                        lock_cnt_d = '0;
                        rst_n_d    = '0;
                        done_d     = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
                HOLD: begin
                    // Lock is deliberately ignored while holding.
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = WAIT_LOCK;
                        lock_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= WAIT_LOCK;
            lock_cnt_q  <= '0;
            dly_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            stage_idx_q <= '0;
            rst_n_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so all registers update together on the edge.
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            dly_cnt_q   <= dly_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            stage_idx_q <= stage_idx_d;
            rst_n_q     <= rst_n_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign rst_n_o    = rst_n_q;
    assign seq_done_o = done_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: an edge-counting reference model
// checked every cycle, plus directed literal checks at key edges.
module tb_rst_seq_ctrl;

    localparam int NUM_STAGES   = 4;
    localparam int STAGE_DLY    = 16;
    localparam int LOCK_FILT    = 8;
    localparam int SOFT_RST_CYC = 32;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic                  pll_lock_i;
    logic                  soft_rst_req_i;
    logic [NUM_STAGES-1:0] rst_n_o;
    logic                  seq_done_o;
    logic                  busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    rst_seq_ctrl #(
        .NUM_STAGES  (NUM_STAGES),
        .STAGE_DLY   (STAGE_DLY),
        .LOCK_FILT   (LOCK_FILT),
        .SOFT_RST_CYC(SOFT_RST_CYC)
    ) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .pll_lock_i    (pll_lock_i),
        .soft_rst_req_i(soft_rst_req_i),
        .rst_n_o       (rst_n_o),
        .seq_done_o    (seq_done_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks how long lock has been good, how many edges
    // have elapsed since the filter was satisfied, and how long a hold lasts.
    // Outputs follow from elapsed time: stage k is free once
    // (k+1)*STAGE_DLY edges have passed since the filter completed.
    typedef enum {M_WAIT, M_SEQ, M_HOLD} mode_e;
    mode_e m_mode     = M_WAIT;
    int    m_lock_run = 0;
    int    m_seq_t    = 0;
    int    m_hold_t   = 0;

    function automatic logic [NUM_STAGES-1:0] exp_rst_n();
        logic [NUM_STAGES-1:0] v = '0;
        if (m_mode == M_SEQ)
            for (int k = 0; k < NUM_STAGES; k++)
                v[k] = (m_seq_t >= (k + 1) * STAGE_DLY);
        return v;
    endfunction

    function automatic logic exp_done();
        return (m_mode == M_SEQ) && (m_seq_t >= NUM_STAGES * STAGE_DLY);
    endfunction

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_mode     = M_WAIT;
            m_lock_run = 0;
            m_seq_t    = 0;
            m_hold_t   = 0;
        end else if (soft_rst_req_i) begin
            m_mode   = M_HOLD;
            m_hold_t = 0;
        end else begin
            case (m_mode)
                M_WAIT: begin
                    if (pll_lock_i) begin
                        m_lock_run++;
                        if (m_lock_run == LOCK_FILT) begin
                            m_mode  = M_SEQ;
                            m_seq_t = 0;
                        end
                    end else begin
                        m_lock_run = 0;
                    end
                end
                M_SEQ: begin
                    if (!pll_lock_i) begin
                        m_mode     = M_WAIT;
                        m_lock_run = 0;
                    end else if (m_seq_t < 100000) begin
                        m_seq_t++;
                    end
                end
                default: begin
                    m_hold_t++;
                    if (m_hold_t == SOFT_RST_CYC) begin
                        m_mode     = M_WAIT;
                        m_lock_run = 0;
                    end
                end
            endcase
        end
        #1;
        check("model_rst_n", 32'(rst_n_o), 32'(exp_rst_n()));
        check("model_done", 32'(seq_done_o), 32'(exp_done()));
        check("model_busy", 32'(busy_o), 32'(!exp_done()));
    end

    // Advance n rising edges, then settle just after the last one.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input logic [3:0] r, input logic d);
        check({name, "_rst_n"}, 32'(rst_n_o), 32'(r));
        check({name, "_done"}, 32'(seq_done_o), 32'(d));
        check({name, "_busy"}, 32'(busy_o), 32'(!d));
    endtask

    // Apply reset, then release it on a falling edge so the next rising edge is edge 1.
    task automatic restart(input logic lock);
        @(negedge clk);
        rst_i      = 1'b0;
        pll_lock_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i      = 1'b1;
        pll_lock_i = lock;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i          = 1'b0;
        pll_lock_i     = 1'b0;
        soft_rst_req_i = 1'b0;
        #12;
        expect_out("reset", 4'b0000, 1'b0);

        // Test 1: lock from reset -> stages at edges 24/40/56/72
        restart(1'b1);
        wait_edges(23); expect_out("t1_e23", 4'b0000, 1'b0);
        wait_edges(1);  expect_out("t1_e24", 4'b0001, 1'b0);
        wait_edges(16); expect_out("t1_e40", 4'b0011, 1'b0);
        wait_edges(16); expect_out("t1_e56", 4'b0111, 1'b0);
        wait_edges(15); expect_out("t1_e71", 4'b0111, 1'b0);
        wait_edges(1);  expect_out("t1_e72", 4'b1111, 1'b1);

        // Test 3: one-cycle lock drop in DONE, then full re-sequence
        wait_edges(3);
        @(negedge clk); pll_lock_i = 1'b0;
        @(negedge clk); pll_lock_i = 1'b1;
        expect_out("t3_drop", 4'b0000, 1'b0);
        wait_edges(23); expect_out("t3_l23", 4'b0000, 1'b0);
        wait_edges(1);  expect_out("t3_l24", 4'b0001, 1'b0);
        wait_edges(48); expect_out("t3_l72", 4'b1111, 1'b1);

        // Test 4: soft pulse in DONE -> 32 hold + 8 filter + 16 per stage
        @(negedge clk); soft_rst_req_i = 1'b1;
        @(negedge clk); soft_rst_req_i = 1'b0;
        expect_out("t4_s0", 4'b0000, 1'b0);
        wait_edges(31); expect_out("t4_s31", 4'b0000, 1'b0);
        wait_edges(24); expect_out("t4_s55", 4'b0000, 1'b0);
        wait_edges(1);  expect_out("t4_s56", 4'b0001, 1'b0);
        wait_edges(16); expect_out("t4_s72", 4'b0011, 1'b0);

        // Test 5: soft request and lock loss together mid-RELEASE -> HOLD
        @(negedge clk); soft_rst_req_i = 1'b1; pll_lock_i = 1'b0;
        @(negedge clk); soft_rst_req_i = 1'b0; pll_lock_i = 1'b1;
        expect_out("t5_x0", 4'b0000, 1'b0);
        wait_edges(24); expect_out("t5_x24", 4'b0000, 1'b0);
        wait_edges(31); expect_out("t5_x55", 4'b0000, 1'b0);
        wait_edges(1);  expect_out("t5_x56", 4'b0001, 1'b0);

        // Test 6: async reset mid-RELEASE clears outputs with no clock edge
        wait_edges(5);
        #1 rst_i = 1'b0;
        #1 expect_out("t6_async", 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        wait_edges(23); expect_out("t6_e23", 4'b0000, 1'b0);
        wait_edges(1);  expect_out("t6_e24", 4'b0001, 1'b0);

        // Test 2: lock low at edge 5 delays everything by 5 edges
        restart(1'b1);
        wait_edges(4);
        @(negedge clk); pll_lock_i = 1'b0;
        @(negedge clk); pll_lock_i = 1'b1;
        wait_edges(23); expect_out("t2_e28", 4'b0000, 1'b0);
        wait_edges(1);  expect_out("t2_e29", 4'b0001, 1'b0);

        // Soft request during HOLD restarts the hold window
        @(negedge clk); soft_rst_req_i = 1'b1;
        @(negedge clk); soft_rst_req_i = 1'b0;
        wait_edges(19);
        @(negedge clk); soft_rst_req_i = 1'b1;
        @(negedge clk); soft_rst_req_i = 1'b0;
        wait_edges(36); expect_out("t7_r36", 4'b0000, 1'b0);
        wait_edges(19); expect_out("t7_r55", 4'b0000, 1'b0);
        wait_edges(1);  expect_out("t7_r56", 4'b0001, 1'b0);

        wait_edges(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
